// File: rtl/mc_stall_sequencer.sv
// Multi-cycle MIPS sequence controller with memory wait states and timeout, a mul/div wait phase,
// an interrupt sampled at fetch entry, and prioritised exception entry with a registered cause code.
module mc_stall_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter bit MULDIV_EN   = 1'b1,
  parameter int CAUSE_W     = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [2:0]         CLASS,
  input  logic               OF_OUT,
  input  logic               MEM_RDY,
  input  logic               MD_DONE,
  input  logic               IRQ,
  output logic               MEM_REQ,
  output logic               IorD,
  output logic               MEM_WS,
  output logic               IR_EN,
  output logic               PC_EN,
  output logic [2:0]         PC_SEL,
  output logic               REG_WS,
  output logic               MD_START,
  output logic               HILO_EN,
  output logic               EPC_EN,
  output logic               CAUSE_EN,
  output logic [CAUSE_W-1:0] CAUSE_CODE,
  output logic               STALL,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    RST_S, FETCH, DECODE, EXEC, MD_WAIT, MEM, WB, EXC
  } state_t;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);
  localparam logic [CAUSE_W-1:0] C_INT  = '0;
  localparam logic [CAUSE_W-1:0] C_IBE  = CAUSE_W'(6);
  localparam logic [CAUSE_W-1:0] C_DBE  = CAUSE_W'(7);
  localparam logic [CAUSE_W-1:0] C_RI   = CAUSE_W'(10);
  localparam logic [CAUSE_W-1:0] C_OVF  = CAUSE_W'(12);

  state_t             state, next;
  logic [2:0]         cls_q;
  logic [7:0]         tmo_cnt;
  logic               irq_q;
  logic [CAUSE_W-1:0] cause_q, cause_next;

  logic       mem_req_c, iord_c, mem_ws_c, ir_en_c, pc_en_c, reg_ws_c;
  logic       md_start_c, hilo_en_c, epc_en_c, cause_en_c, stall_c;
  logic [2:0] pc_sel_c;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= RST_S;
      cls_q   <= '0;
      tmo_cnt <= '0;
      irq_q   <= 1'b0;
      cause_q <= '0;
    end else begin
      state <= next;
      if (state == DECODE) cls_q <= CLASS;
      if (next == EXC) cause_q <= cause_next;
      // Interrupt is sampled only on the edge that enters FETCH
      if (next == FETCH && state != FETCH) irq_q <= IRQ;
      if (next != state) tmo_cnt <= '0;
      else if (mem_req_c && !MEM_RDY) tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  always_comb begin
    next       = state;
    cause_next = '0;
    mem_req_c  = 1'b0;
    iord_c     = 1'b0;
    mem_ws_c   = 1'b0;
    ir_en_c    = 1'b0;
    pc_en_c    = 1'b0;
    pc_sel_c   = 3'd0;
    reg_ws_c   = 1'b0;
    md_start_c = 1'b0;
    hilo_en_c  = 1'b0;
    epc_en_c   = 1'b0;
    cause_en_c = 1'b0;
    stall_c    = 1'b0;
    case (state)
      RST_S: next = FETCH;
      FETCH: begin
        if (irq_q) begin
          next       = EXC;
          cause_next = C_INT;
        end else begin
          mem_req_c = 1'b1;
          if (MEM_RDY) begin
            ir_en_c = 1'b1;
            pc_en_c = 1'b1;
            next    = DECODE;
          end else begin
            stall_c = 1'b1;
            if (tmo_cnt == TMO) begin
              next       = EXC;
              cause_next = C_IBE;
            end
          end
        end
      end
      DECODE: begin
        case (CLASS)
          3'd0, 3'd1, 3'd2, 3'd3: next = EXEC;
          3'd4: begin
            pc_en_c  = 1'b1;
            pc_sel_c = 3'd1;
            next     = FETCH;
          end
          3'd5: begin
            pc_en_c  = 1'b1;
            pc_sel_c = 3'd2;
            next     = FETCH;
          end
          3'd6: begin
            if (MULDIV_EN) begin
              md_start_c = 1'b1;
              next       = MD_WAIT;
            end else begin
              next       = EXC;
              cause_next = C_RI;
            end
          end
          default: begin
            next       = EXC;
            cause_next = C_RI;
          end
        endcase
      end
      EXEC: begin
        if (cls_q == 3'd0 || cls_q == 3'd1) begin
          if (OF_OUT) begin
            next       = EXC;
            cause_next = C_OVF;
          end else begin
            next = WB;
          end
        end else begin
          next = MEM;
        end
      end
      MD_WAIT: begin
        if (MD_DONE) begin
          hilo_en_c = 1'b1;
          next      = FETCH;
        end else begin
          stall_c = 1'b1;
        end
      end
      MEM: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        mem_ws_c  = (cls_q == 3'd3);
        if (MEM_RDY) begin
          next = (cls_q == 3'd2) ? WB : FETCH;
        end else begin
          stall_c = 1'b1;
          if (tmo_cnt == TMO) begin
            next       = EXC;
            cause_next = C_DBE;
          end
        end
      end
      WB: begin
        reg_ws_c = 1'b1;
        next     = FETCH;
      end
      EXC: begin
        epc_en_c   = 1'b1;
        cause_en_c = 1'b1;
        pc_en_c    = 1'b1;
        pc_sel_c   = 3'd4;
        next       = FETCH;
      end
      default: next = RST_S;
    endcase
  end

  // Reset forces every strobe low in the same cycle so nothing partial is committed
  assign MEM_REQ    = !RST && mem_req_c;
  assign IorD       = !RST && iord_c;
  assign MEM_WS     = !RST && mem_ws_c;
  assign IR_EN      = !RST && ir_en_c;
  assign PC_EN      = !RST && pc_en_c;
  assign PC_SEL     = RST ? 3'd0 : pc_sel_c;
  assign REG_WS     = !RST && reg_ws_c;
  assign MD_START   = !RST && md_start_c;
  assign HILO_EN    = !RST && hilo_en_c;
  assign EPC_EN     = !RST && epc_en_c;
  assign CAUSE_EN   = !RST && cause_en_c;
  assign STALL      = !RST && stall_c;
  assign CAUSE_CODE = cause_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_mc_stall_sequencer.sv
// Directed bench for mc_stall_sequencer: one instance with mul/div enabled, a second with it
// disabled fed the same stimulus; both use a 4-cycle memory timeout.
module tb_mc_stall_sequencer;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] CLASS = 3'd0;
  logic       OF_OUT = 1'b0, MEM_RDY = 1'b0, MD_DONE = 1'b0, IRQ = 1'b0;

  logic       mem_req_a, iord_a, mem_ws_a, ir_en_a, pc_en_a, reg_ws_a;
  logic       md_start_a, hilo_en_a, epc_en_a, cause_en_a, stall_a;
  logic [2:0] pc_sel_a, dbg_a;
  logic [4:0] cause_a;
  logic       mem_req_b, iord_b, mem_ws_b, ir_en_b, pc_en_b, reg_ws_b;
  logic       md_start_b, hilo_en_b, epc_en_b, cause_en_b, stall_b;
  logic [2:0] pc_sel_b, dbg_b;
  logic [4:0] cause_b;

  int total = 0;
  int bad   = 0;

  // Packed: MEM_REQ IorD MEM_WS IR_EN PC_EN PC_SEL[2:0] REG_WS MD_START HILO_EN EPC_EN CAUSE_EN STALL
  logic [13:0] outs_a, outs_b;
  assign outs_a = {mem_req_a, iord_a, mem_ws_a, ir_en_a, pc_en_a, pc_sel_a, reg_ws_a,
                   md_start_a, hilo_en_a, epc_en_a, cause_en_a, stall_a};
  assign outs_b = {mem_req_b, iord_b, mem_ws_b, ir_en_b, pc_en_b, pc_sel_b, reg_ws_b,
                   md_start_b, hilo_en_b, epc_en_b, cause_en_b, stall_b};

  localparam logic [13:0] O_NONE  = 14'h0000;
  localparam logic [13:0] O_FWAIT = 14'h2001;
  localparam logic [13:0] O_FDONE = 14'h2600;
  localparam logic [13:0] O_WB    = 14'h0020;
  localparam logic [13:0] O_LWAIT = 14'h3001;
  localparam logic [13:0] O_LDONE = 14'h3000;
  localparam logic [13:0] O_SWAIT = 14'h3801;
  localparam logic [13:0] O_SDONE = 14'h3800;
  localparam logic [13:0] O_BR    = 14'h0240;
  localparam logic [13:0] O_JMP   = 14'h0280;
  localparam logic [13:0] O_MDS   = 14'h0010;
  localparam logic [13:0] O_MDW   = 14'h0001;
  localparam logic [13:0] O_MDD   = 14'h0008;
  localparam logic [13:0] O_EXC   = 14'h0306;

  mc_stall_sequencer #(.MEM_TIMEOUT(4), .MULDIV_EN(1'b1), .CAUSE_W(5)) u_dut_a (
    .CLK(CLK), .RST(RST), .CLASS(CLASS), .OF_OUT(OF_OUT), .MEM_RDY(MEM_RDY),
    .MD_DONE(MD_DONE), .IRQ(IRQ), .MEM_REQ(mem_req_a), .IorD(iord_a), .MEM_WS(mem_ws_a),
    .IR_EN(ir_en_a), .PC_EN(pc_en_a), .PC_SEL(pc_sel_a), .REG_WS(reg_ws_a),
    .MD_START(md_start_a), .HILO_EN(hilo_en_a), .EPC_EN(epc_en_a), .CAUSE_EN(cause_en_a),
    .CAUSE_CODE(cause_a), .STALL(stall_a), .dbg_state(dbg_a));

  mc_stall_sequencer #(.MEM_TIMEOUT(4), .MULDIV_EN(1'b0), .CAUSE_W(5)) u_dut_b (
    .CLK(CLK), .RST(RST), .CLASS(CLASS), .OF_OUT(OF_OUT), .MEM_RDY(MEM_RDY),
    .MD_DONE(MD_DONE), .IRQ(IRQ), .MEM_REQ(mem_req_b), .IorD(iord_b), .MEM_WS(mem_ws_b),
    .IR_EN(ir_en_b), .PC_EN(pc_en_b), .PC_SEL(pc_sel_b), .REG_WS(reg_ws_b),
    .MD_START(md_start_b), .HILO_EN(hilo_en_b), .EPC_EN(epc_en_b), .CAUSE_EN(cause_en_b),
    .CAUSE_CODE(cause_b), .STALL(stall_b), .dbg_state(dbg_b));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One cycle: drive inputs, let outputs settle mid-cycle, compare, advance.
  task automatic run(input string tag, input logic [2:0] cls, input logic rdy, input logic of,
                     input logic md, input logic irq, input logic [13:0] exp);
    CLASS = cls; MEM_RDY = rdy; OF_OUT = of; MD_DONE = md; IRQ = irq;
    #2;
    chk(tag, 32'(outs_a), 32'(exp));
    tick();
  endtask

  initial begin
    tick();
    // Reset and RST_S cycles
    #2;
    chk("rst_outs", 32'(outs_a), 32'(O_NONE));
    chk("rst_cause", 32'(cause_a), 32'd0);
    tick();
    RST = 1'b0;
    run("rsts_outs", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE);

    // ALU_R, zero wait: FETCH DECODE EXEC WB, then FETCH again
    run("alu_fetch", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_FDONE);
    run("alu_dec",   3'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
    run("alu_exec",  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
    run("alu_wb",    3'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_WB);

    // LOAD with 3 data wait states; CLASS toggled to STORE mid-way must be ignored
    run("ld_fetch", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_FDONE);
    run("ld_dec",   3'd2, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
    run("ld_exec",  3'd3, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
    for (int i = 0; i < 3; i++) run("ld_wait", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, O_LWAIT);
    run("ld_rdy",   3'd3, 1'b1, 1'b0, 1'b0, 1'b0, O_LDONE);
    run("ld_wb",    3'd3, 1'b0, 1'b0, 1'b0, 1'b0, O_WB);

    // STORE, zero wait
    run("st_fetch", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_FDONE);
    run("st_dec",   3'd3, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
    run("st_exec",  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
    run("st_mem",   3'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_SDONE);

    // Branch and jump
    run("br_fetch", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_FDONE);
    run("br_dec",   3'd4, 1'b0, 1'b0, 1'b0, 1'b0, O_BR);
    run("j_fetch",  3'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_FDONE);
    run("j_dec",    3'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_JMP);

    // Fetch timeout: 5 request cycles, then EXC with cause 6
    for (int i = 0; i < 5; i++) run("ftmo_wait", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_FWAIT);
    #2 chk("ftmo_cause", 32'(cause_a), 32'd6);
    run("ftmo_exc", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_EXC);

    // Data timeout on a load: cause 7
    run("dtmo_fetch", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_FDONE);
    run("dtmo_dec",   3'd2, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
    run("dtmo_exec",  3'd2, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
    for (int i = 0; i < 5; i++) run("dtmo_wait", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, O_LWAIT);
    #2 chk("dtmo_cause", 32'(cause_a), 32'd7);
    run("dtmo_exc", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_EXC);

    // ALU_I overflow: no REG_WS, EXC cause 12, cause held afterwards
    run("ovf_fetch", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_FDONE);
    run("ovf_dec",   3'd1, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
    run("ovf_exec",  3'd1, 1'b0, 1'b1, 1'b0, 1'b0, O_NONE);
    #2 chk("ovf_cause", 32'(cause_a), 32'd12);
    run("ovf_exc",   3'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_EXC);
    #2 chk("ovf_hold", 32'(cause_a), 32'd12);

    // Invalid class: cause 10
    run("inv_fetch", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_FDONE);
    run("inv_dec",   3'd7, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
    #2 chk("inv_cause", 32'(cause_a), 32'd10);
    run("inv_exc",   3'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_EXC);

    // Reset during a store wait state: outputs drop at once, restart via RST_S
    run("rm_fetch", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_FDONE);
    run("rm_dec",   3'd3, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
    run("rm_exec",  3'd3, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
    run("rm_wait",  3'd3, 1'b0, 1'b0, 1'b0, 1'b0, O_SWAIT);
    RST = 1'b1;
    run("rm_rst",   3'd3, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
    RST = 1'b0;
    #2 chk("rm_cause", 32'(cause_a), 32'd0);
    run("rm_rsts",  3'd3, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);
    run("rm_fetch2", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_FDONE);

    // Mul/div: one MD_START, MD_DONE on the 6th wait cycle; disabled instance takes cause 10
    run("md_dec", 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, O_MDS);
    CLASS = 3'd0; MEM_RDY = 1'b0; OF_OUT = 1'b0; MD_DONE = 1'b0; IRQ = 1'b0;
    #2;
    chk("md_wait0", 32'(outs_a), 32'(O_MDW));
    chk("nomd_exc", 32'(outs_b), 32'(O_EXC));
    chk("nomd_cause", 32'(cause_b), 32'd10);
    tick();
    for (int i = 0; i < 4; i++) run("md_wait", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_MDW);
    // IRQ present on the edge entering FETCH
    run("md_done", 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_MDD);

    // Interrupt at fetch entry: no request, EXC with cause 0
    run("irq_fetch", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, O_NONE);
    #2 chk("irq_cause", 32'(cause_a), 32'd0);
    run("irq_exc",   3'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_EXC);
    run("irq_after", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_FWAIT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
